// File: rtl/hdmi_clk_sequencer_pkg.sv
// Shared types and default timing for the HDMI clock-tree power-up sequencer.
package hdmi_clk_sequencer_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        SETTLE,
        DIV_REL,
        RUN,
        FAULT
    } clkseq_state_t;

    localparam int DEF_PLL_RST_CYC  = 16;
    localparam int DEF_LOCK_TMO_CYC = 270000;
    localparam int DEF_SETTLE_CYC   = 2700;
    localparam int DEF_DIV_DLY_CYC  = 64;
    localparam int DEF_DBNC_CYC     = 270000;
    localparam int DEF_MAX_RETRY    = 7;

    typedef struct packed {
        logic pll_reset;
        logic clkdiv_rstn;
        logic pixel_rst_n;
        logic audio_en;
        logic ready;
        logic fault;
    } clkseq_out_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Moore output decode; PLL_RST doubles as the reset value.
    function automatic clkseq_out_t state_outputs(input clkseq_state_t s);
        clkseq_out_t o;
        o = '0;
        o.pll_reset = 1'b1;
        case (s)
            WAIT_LOCK, SETTLE: o.pll_reset = 1'b0;
            DIV_REL: begin
                o.pll_reset   = 1'b0;
                o.clkdiv_rstn = 1'b1;
            end
            RUN: begin
                o.pll_reset   = 1'b0;
                o.clkdiv_rstn = 1'b1;
                o.pixel_rst_n = 1'b1;
                o.audio_en    = 1'b1;
                o.ready       = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/hdmi_clk_sequencer_btn_debounce.sv
// Reset-button synchroniser plus stable-count filter; emits a one-cycle press
// pulse when the accepted level falls.
module hdmi_clk_sequencer_btn_debounce #(
    parameter int DBNC_CYC = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DBNC_CYC > 1) ? $clog2(DBNC_CYC) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DBNC_CYC - 1);

    logic          btn_s1;
    logic          btn_s;
    logic          btn_last;
    logic          btn_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b1;
            btn_s    <= 1'b1;
            btn_last <= 1'b1;
            btn_d    <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            btn_s1   <= btn_n;
            btn_s    <= btn_s1;
            btn_last <= btn_s;
            press    <= 1'b0;
            if (btn_s != btn_last || btn_s == btn_d) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                btn_d <= btn_s;
                cnt   <= '0;
                press <= btn_d & ~btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdmi_clk_sequencer.sv
// Power-up / recovery sequencer for the rPLL -> CLKDIV -> pixel/audio clock tree.
// state     | meaning
// PLL_RST   | rPLL held in reset for PLL_RST_CYC
// WAIT_LOCK | waiting for lock, retry on timeout
// SETTLE    | lock must stay high SETTLE_CYC
// DIV_REL   | CLKDIV released, pixel reset still held
// RUN       | everything released
// FAULT     | retries exhausted, wait for button
module hdmi_clk_sequencer
    import hdmi_clk_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
    parameter int LOCK_TMO_CYC = DEF_LOCK_TMO_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int DIV_DLY_CYC  = DEF_DIV_DLY_CYC,
    parameter int DBNC_CYC     = DEF_DBNC_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_pll_lock,
    input  logic       I_btn_n,
    output logic       O_pll_reset,
    output logic       O_clkdiv_rstn,
    output logic       O_pixel_rst_n,
    output logic       O_audio_en,
    output logic       O_ready,
    output logic       O_fault,
    output logic [2:0] O_retry_cnt
);
    localparam int TMAX = max_int(LOCK_TMO_CYC, DBNC_CYC);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TC_PLL    = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] TC_TMO    = TW'(LOCK_TMO_CYC - 1);
    localparam logic [TW-1:0] TC_SETTLE = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TC_DIV    = TW'(DIV_DLY_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX = '1;
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    clkseq_state_t state;
    clkseq_out_t   outs;
    logic [TW-1:0] timer;
    logic [2:0]    retry_cnt;
    logic          lock_s1;
    logic          lock;
    logic          btn_press;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            lock_s1 <= 1'b0;
            lock    <= 1'b0;
        end else begin
            lock_s1 <= I_pll_lock;
            lock    <= lock_s1;
        end
    end

    hdmi_clk_sequencer_btn_debounce #(
        .DBNC_CYC (DBNC_CYC)
    ) u_btn_debounce (
        .clk   (I_clk),
        .rst   (I_rst),
        .btn_n (I_btn_n),
        .press (btn_press)
    );

    // Every transition clears the timer; otherwise it counts up and saturates.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state     <= PLL_RST;
            outs      <= state_outputs(PLL_RST);
            timer     <= '0;
            retry_cnt <= '0;
        end else begin
            timer <= (timer == TIMER_MAX) ? timer : timer + 1'b1;
            if (btn_press) begin
                state     <= PLL_RST;
                outs      <= state_outputs(PLL_RST);
                timer     <= '0;
                retry_cnt <= '0;
            end else begin
                unique case (state)
                    PLL_RST: begin
                        if (timer == TC_PLL) begin
                            state <= WAIT_LOCK;
                            outs  <= state_outputs(WAIT_LOCK);
                            timer <= '0;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock) begin
                            state <= SETTLE;
                            outs  <= state_outputs(SETTLE);
                            timer <= '0;
                        end else if (timer == TC_TMO) begin
                            timer <= '0;
                            if (retry_cnt == RETRY_MAX) begin
                                state <= FAULT;
                                outs  <= state_outputs(FAULT);
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= PLL_RST;
                                outs      <= state_outputs(PLL_RST);
                            end
                        end
                    end
                    SETTLE: begin
                        if (!lock) begin
                            state <= WAIT_LOCK;
                            outs  <= state_outputs(WAIT_LOCK);
                            timer <= '0;
                        end else if (timer == TC_SETTLE) begin
                            state <= DIV_REL;
                            outs  <= state_outputs(DIV_REL);
                            timer <= '0;
                        end
                    end
                    DIV_REL: begin
                        if (!lock) begin
                            state <= PLL_RST;
                            outs  <= state_outputs(PLL_RST);
                            timer <= '0;
                        end else if (timer == TC_DIV) begin
                            state     <= RUN;
                            outs      <= state_outputs(RUN);
                            timer     <= '0;
                            retry_cnt <= '0;
                        end
                    end
                    RUN: begin
                        if (!lock) begin
                            state <= PLL_RST;
                            outs  <= state_outputs(PLL_RST);
                            timer <= '0;
                        end
                    end
                    FAULT: ;
                    default: begin
                        state <= PLL_RST;
                        outs  <= state_outputs(PLL_RST);
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    assign O_pll_reset   = outs.pll_reset;
    assign O_clkdiv_rstn = outs.clkdiv_rstn;
    assign O_pixel_rst_n = outs.pixel_rst_n;
    assign O_audio_en    = outs.audio_en;
    assign O_ready       = outs.ready;
    assign O_fault       = outs.fault;
    assign O_retry_cnt   = retry_cnt;

endmodule

// File: tb/tb_hdmi_clk_sequencer.sv
// Directed bench for hdmi_clk_sequencer: per-cycle vector tables plus a few
// hand-written corner sequences (button bounce, async reset in DIV_REL).
module tb_hdmi_clk_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       btn_n;
    logic       pll_reset;
    logic       clkdiv_rstn;
    logic       pixel_rst_n;
    logic       audio_en;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output bits: {pll_reset, clkdiv_rstn, pixel_rst_n, audio_en, ready, fault}
    typedef struct {
        logic       lk;
        logic       bn;
        logic [5:0] ex;
        logic [2:0] rc;
    } vec_t;

    vec_t vecs[$];

    hdmi_clk_sequencer #(
        .PLL_RST_CYC  (4),
        .LOCK_TMO_CYC (20),
        .SETTLE_CYC   (5),
        .DIV_DLY_CYC  (3),
        .DBNC_CYC     (8),
        .MAX_RETRY    (2)
    ) dut (
        .I_clk         (clk),
        .I_rst         (rst),
        .I_pll_lock    (pll_lock),
        .I_btn_n       (btn_n),
        .O_pll_reset   (pll_reset),
        .O_clkdiv_rstn (clkdiv_rstn),
        .O_pixel_rst_n (pixel_rst_n),
        .O_audio_en    (audio_en),
        .O_ready       (ready),
        .O_fault       (fault),
        .O_retry_cnt   (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"},   int'(pll_reset),   1);
        check({tag, "_clkdiv_rstn"}, int'(clkdiv_rstn), 0);
        check({tag, "_pixel_rst_n"}, int'(pixel_rst_n), 0);
        check({tag, "_audio_en"},    int'(audio_en),    0);
        check({tag, "_ready"},       int'(ready),       0);
        check({tag, "_fault"},       int'(fault),       0);
        check({tag, "_retry_cnt"},   int'(retry_cnt),   0);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        pll_lock = 1'b0;
        btn_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values(tag);
        rst = 1'b0;
    endtask

    task automatic add(input int n, input logic lk, input logic bn,
                       input logic [5:0] ex, input logic [2:0] rc);
        repeat (n) vecs.push_back('{lk: lk, bn: bn, ex: ex, rc: rc});
    endtask

    // Record i drives the inputs sampled at edge i; outputs are checked just after it.
    task automatic run_vectors(input string tag);
        logic [5:0] got;
        for (int i = 0; i < vecs.size(); i++) begin
            pll_lock = vecs[i].lk;
            btn_n    = vecs[i].bn;
            @(posedge clk);
            #1;
            got = {pll_reset, clkdiv_rstn, pixel_rst_n, audio_en, ready, fault};
            check($sformatf("%s_out[%0d]", tag, i + 1), int'(got), int'(vecs[i].ex));
            check($sformatf("%s_retry[%0d]", tag, i + 1), int'(retry_cnt), int'(vecs[i].rc));
            check($sformatf("%s_order[%0d]", tag, i + 1),
                  int'((!pixel_rst_n || clkdiv_rstn) && (!clkdiv_rstn || !pll_reset)), 1);
        end
        vecs.delete();
    endtask

    initial begin
        int   restarts;
        logic prev;
        logic ok;

        rst      = 1'b1;
        pll_lock = 1'b0;
        btn_n    = 1'b1;

        // Normal bring-up, lock 6 cycles after PLL reset release, then lock loss in RUN.
        do_reset("rst_a");
        add(3, 1'b0, 1'b1, 6'b100000, 3'd0);   // edges 1-3   PLL_RST
        add(7, 1'b0, 1'b1, 6'b000000, 3'd0);   // edges 4-10  WAIT_LOCK
        add(7, 1'b1, 1'b1, 6'b000000, 3'd0);   // edges 11-17 lock syncing, SETTLE 13-17
        add(3, 1'b1, 1'b1, 6'b010000, 3'd0);   // edges 18-20 DIV_REL
        add(4, 1'b1, 1'b1, 6'b011110, 3'd0);   // edges 21-24 RUN
        add(2, 1'b0, 1'b1, 6'b011110, 3'd0);   // edges 25-26 drop still in synchroniser
        add(2, 1'b0, 1'b1, 6'b100000, 3'd0);   // edges 27-28 PLL_RST
        add(2, 1'b1, 1'b1, 6'b100000, 3'd0);   // edges 29-30 PLL_RST
        add(6, 1'b1, 1'b1, 6'b000000, 3'd0);   // edges 31-36 WAIT_LOCK then SETTLE
        add(3, 1'b1, 1'b1, 6'b010000, 3'd0);   // edges 37-39 DIV_REL
        add(3, 1'b1, 1'b1, 6'b011110, 3'd0);   // edges 40-42 RUN
        run_vectors("seq");

        // One-cycle lock glitch during SETTLE restarts the settle window.
        do_reset("rst_b");
        add(3, 1'b1, 1'b1, 6'b100000, 3'd0);   // edges 1-3
        add(3, 1'b1, 1'b1, 6'b000000, 3'd0);   // edges 4-6
        add(1, 1'b0, 1'b1, 6'b000000, 3'd0);   // edge 7 glitch
        add(7, 1'b1, 1'b1, 6'b000000, 3'd0);   // edges 8-14
        add(3, 1'b1, 1'b1, 6'b010000, 3'd0);   // edges 15-17 DIV_REL
        add(2, 1'b1, 1'b1, 6'b011110, 3'd0);   // edges 18-19 RUN
        run_vectors("glitch");

        // Button bouncing with 3-cycle pulses must not disturb RUN.
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn_n = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (!ready || pll_reset) ok = 1'b0;
        end
        check("bounce_no_restart", int'(ok), 1);

        // Clean press: exactly one restart, then back to RUN.
        restarts = 0;
        prev     = pll_reset;
        for (int i = 0; i < 60; i++) begin
            btn_n = (i < 20) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (pll_reset && !prev) restarts++;
            prev = pll_reset;
        end
        check("press_restart_count", restarts, 1);
        check("press_back_in_run", int'(ready), 1);

        // Lock never arrives: three attempts, FAULT, then a press clears it.
        do_reset("rst_c");
        add(3,  1'b0, 1'b1, 6'b100000, 3'd0);  // edges 1-3
        add(20, 1'b0, 1'b1, 6'b000000, 3'd0);  // edges 4-23
        add(4,  1'b0, 1'b1, 6'b100000, 3'd1);  // edges 24-27
        add(20, 1'b0, 1'b1, 6'b000000, 3'd1);  // edges 28-47
        add(4,  1'b0, 1'b1, 6'b100000, 3'd2);  // edges 48-51
        add(20, 1'b0, 1'b1, 6'b000000, 3'd2);  // edges 52-71
        add(5,  1'b0, 1'b1, 6'b100001, 3'd2);  // edges 72-76 FAULT
        add(11, 1'b0, 1'b0, 6'b100001, 3'd2);  // edges 77-87 button debouncing
        add(4,  1'b0, 1'b0, 6'b100000, 3'd0);  // edges 88-91 PLL_RST
        add(2,  1'b0, 1'b0, 6'b000000, 3'd0);  // edges 92-93 WAIT_LOCK
        run_vectors("retry");

        // Async reset while in DIV_REL.
        do_reset("rst_d");
        pll_lock = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("divrel_clkdiv_rstn", int'(clkdiv_rstn), 1);
        check("divrel_pixel_rst_n", int'(pixel_rst_n), 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("restart_pll_reset_held", int'(pll_reset), 1);
        @(posedge clk);
        #1;
        check("restart_pll_reset_released", int'(pll_reset), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
